alu_nibble_sequencer: RTL and testbench

Sequential front end for the 4-bit 74181-style `ALU`. It accepts one multi-nibble operation per command over a valid/ready handshake and drives the ALU one nibble per cycle, LSB nibble first. It chains the active-low carry between nibbles, captures each result nibble and the nibble flags, and returns the full-width result over a second valid/ready handshake. It sits directly upstream of `ALU`, driving `a`, `b`, `s`, `M` and `Ci_inverse`, and directly downstream of it, consuming `Y`, `Co_inverse` and `AequalsB`.

---
 rtl/alu_nibble_sequencer_if.sv | 37 +++
 rtl/alu_nibble_sequencer.sv | 95 +++++++++
 tb/tb_alu_nibble_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if: command, response and nibble-ALU buses of the sequencer
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
   localparam int W = 4 * NIBBLES;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_s;
   logic         cmd_m;
   logic         cmd_cin_n;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic [3:0]   alu_s;
   logic         alu_m;
   logic         alu_ci_n;
   logic [3:0]   alu_y;
   logic         alu_co_n;
   logic         alu_aeqb;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_y;
   logic         rsp_cout_n;
   logic         rsp_aeqb;
   logic         rsp_zero;
   modport master (
      output cmd_valid, cmd_s, cmd_m, cmd_cin_n, cmd_a, cmd_b, rsp_ready,
             alu_y, alu_co_n, alu_aeqb,
      input  cmd_ready, alu_a, alu_b, alu_s, alu_m, alu_ci_n,
             rsp_valid, rsp_y, rsp_cout_n, rsp_aeqb, rsp_zero
   );
   modport slave (
      input  cmd_valid, cmd_s, cmd_m, cmd_cin_n, cmd_a, cmd_b, rsp_ready,
             alu_y, alu_co_n, alu_aeqb,
      output cmd_ready, alu_a, alu_b, alu_s, alu_m, alu_ci_n,
             rsp_valid, rsp_y, rsp_cout_n, rsp_aeqb, rsp_zero
   );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a 4-bit 74181-style ALU one nibble per cycle, LSB first, chaining carry
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input logic clk,
   input logic reset,
   alu_nibble_sequencer_if.slave bus
);
   localparam int W = 4 * NIBBLES;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t       state;
   logic [2:0]   idx;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] y_q;
   logic         cout_q;
   logic         aeqb_q;
   logic         cmd_ready_q;
   logic         rsp_valid_q;
   logic [3:0]   alu_a_q;
   logic [3:0]   alu_b_q;
   logic [3:0]   alu_s_q;
   logic         alu_m_q;
   logic         alu_ci_n_q;
   logic         last;
   assign last = idx == 3'(NIBBLES - 1);
   // Operand registers shift right so the next nibble is always at the bottom
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         y_q         <= '0;
         cout_q      <= 1'b1;
         aeqb_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_s_q     <= '0;
         alu_m_q     <= 1'b0;
         alu_ci_n_q  <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               state       <= RUN;
               cmd_ready_q <= 1'b0;
               idx         <= '0;
               y_q         <= '0;
               aeqb_q      <= 1'b1;
               a_q         <= bus.cmd_a >> 4;
               b_q         <= bus.cmd_b >> 4;
               alu_a_q     <= bus.cmd_a[3:0];
               alu_b_q     <= bus.cmd_b[3:0];
               alu_s_q     <= bus.cmd_s;
               alu_m_q     <= bus.cmd_m;
               alu_ci_n_q  <= bus.cmd_cin_n;
            end
            RUN: begin
               y_q[4*idx +: 4] <= bus.alu_y;
               aeqb_q      <= aeqb_q & bus.alu_aeqb;
               cout_q      <= bus.alu_co_n;
               idx         <= idx + 3'd1;
               a_q         <= a_q >> 4;
               b_q         <= b_q >> 4;
               state       <= last ? DONE : RUN;
               rsp_valid_q <= last;
               alu_a_q     <= last ? 4'd0 : a_q[3:0];
               alu_b_q     <= last ? 4'd0 : b_q[3:0];
               alu_s_q     <= last ? 4'd0 : alu_s_q;
               alu_m_q     <= last ? 1'b0 : alu_m_q;
               alu_ci_n_q  <= last ? 1'b1 : bus.alu_co_n;
            end
            DONE: if (bus.rsp_ready) begin
               state       <= IDLE;
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_y      = y_q;
   assign bus.rsp_cout_n = cout_q;
   assign bus.rsp_aeqb   = aeqb_q;
   assign bus.rsp_zero   = ~|y_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_s      = alu_s_q;
   assign bus.alu_m      = alu_m_q;
   assign bus.alu_ci_n   = alu_ci_n_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: random and directed operations checked against a full-width 74181 reference
module tb_alu_nibble_sequencer;
   localparam int N = 4;
   localparam int W = 4 * N;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   logic [32:0] r4;
   always #5 clk = ~clk;
   alu_nibble_sequencer_if #(.NIBBLES(N)) bus();
   alu_nibble_sequencer #(.NIBBLES(N)) dut (.clk(clk), .reset(reset), .bus(bus));
   // 74181 of any width: result = X + Y + c (arith) or ~(X ^ Y) (logic); bit 32 = active-low carry out
   function automatic logic [32:0] alu_fn(int w, logic [3:0] s, logic m, logic cin_n, logic [31:0] a, logic [31:0] b);
      logic [32:0] mask, aa, bb, nb, x, y, sum, f;
      mask = (33'd1 << w) - 33'd1;
      aa = {1'b0, a} & mask;
      bb = {1'b0, b} & mask;
      nb = ~{1'b0, b} & mask;
      x = aa | (s[0] ? bb : 33'd0) | (s[1] ? nb : 33'd0);
      y = (s[2] ? (aa & nb) : 33'd0) | (s[3] ? (aa & bb) : 33'd0);
      sum = x + y + (cin_n ? 33'd0 : 33'd1);
      f = m ? (~(x ^ y) & mask) : (sum & mask);
      return {~sum[w], f[31:0]};
   endfunction
   always_comb begin
      r4 = alu_fn(4, bus.alu_s, bus.alu_m, bus.alu_ci_n, {28'd0, bus.alu_a}, {28'd0, bus.alu_b});
      bus.alu_y = r4[3:0];
      bus.alu_co_n = r4[32];
      bus.alu_aeqb = r4[3:0] == 4'hF;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_reset_values();
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_y", bus.rsp_y, 0);
      check("rst_cout_n", bus.rsp_cout_n, 1);
      check("rst_aeqb", bus.rsp_aeqb, 0);
      check("rst_zero", bus.rsp_zero, 1);
      check("rst_alu_ab", {bus.alu_a, bus.alu_b, bus.alu_s}, 0);
      check("rst_alu_m", bus.alu_m, 0);
      check("rst_alu_ci_n", bus.alu_ci_n, 1);
   endtask
   task automatic run_op(input logic [3:0] s, input logic m, input logic cin_n,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [32:0] r;
      logic [W-1:0] ey;
      logic prev_co;
      int cnt;
      r = alu_fn(W, s, m, cin_n, 32'(a), 32'(b));
      ey = r[W-1:0];
      prev_co = 1'b1;
      @(negedge clk);
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_s = s;
      bus.cmd_m = m;
      bus.cmd_cin_n = cin_n;
      bus.cmd_a = a;
      bus.cmd_b = b;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = hold == 0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cnt = 1;
      while (!bus.rsp_valid && cnt < 20) begin
         if (cnt <= N) begin
            check("alu_a_nibble", bus.alu_a, (a >> (4 * (cnt - 1))) & 4'hF);
            check("alu_ci_chain", bus.alu_ci_n, cnt == 1 ? cin_n : prev_co);
            prev_co = bus.alu_co_n;
         end
         @(negedge clk);
         cnt++;
      end
      check("latency", cnt, N + 1);
      check("rsp_y", bus.rsp_y, ey);
      check("rsp_cout_n", bus.rsp_cout_n, r[32]);
      check("rsp_aeqb", bus.rsp_aeqb, ey == '1);
      check("rsp_zero", bus.rsp_zero, ey == '0);
      for (int k = 0; k < hold; k++) begin
         bus.cmd_valid = k == 3;
         bus.cmd_a = ~a;
         @(negedge clk);
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_rsp", {bus.rsp_y, bus.rsp_cout_n, bus.rsp_aeqb}, {ey, r[32], ey == '1});
         check("hold_cmd_ready", bus.cmd_ready, 0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("idle_after_rsp", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
      check("idle_keeps_y", bus.rsp_y, ey);
      check("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_ci_n}, 14'd1);
   endtask
   initial begin
      logic seen;
      bus.cmd_valid = 1'b0;
      bus.cmd_s = '0;
      bus.cmd_m = 1'b0;
      bus.cmd_cin_n = 1'b1;
      bus.cmd_a = '0;
      bus.cmd_b = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values();
      reset = 1'b0;
      run_op(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, 0);
      run_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 0);
      run_op(4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003, 0);
      run_op(4'b0110, 1'b0, 1'b1, 16'h1234, 16'h1234, 0);
      run_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 0);
      run_op(4'b1001, 1'b0, 1'b1, 16'h1357, 16'h2468, 10);
      @(negedge clk);
      bus.cmd_s = 4'b1001;
      bus.cmd_m = 1'b0;
      bus.cmd_cin_n = 1'b1;
      bus.cmd_a = 16'h0FFF;
      bus.cmd_b = 16'h0001;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values();
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= bus.rsp_valid;
      end
      check("no_rsp_after_reset", seen, 0);
      run_op(4'b1001, 1'b0, 1'b1, 16'h0FFF, 16'h0001, 0);
      for (int t = 0; t < 40; t++)
         run_op(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                16'($urandom), 16'($urandom), int'($urandom_range(2)));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
